pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 80 ++++++++
 tb/tb_pipe_stage_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline register between adjacent CPU stages with bubble flush
// and stall-cycle monitoring for debug and performance counting.
module pipe_stage_reg #(
    parameter int PC_W             = 32,
    parameter int INSTR_W          = 32,
    parameter int SIDE_W           = 8,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1,
    parameter int CNT_W            = 8,
    parameter int STALL_LIMIT      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [PC_W-1:0]    pc_plus4_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [SIDE_W-1:0]  side_in,
    output logic               valid_out,
    output logic [PC_W-1:0]    pc_plus4_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [SIDE_W-1:0]  side_out,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   stall_total,
    output logic               stall_timeout
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             stall_ev;
    logic [CNT_W-1:0] cnt_nxt;

    // Holding a bubble is not a stall: only valid content counts.
    assign stall_ev = !flush && !en && valid_out;

    always_comb begin
        cnt_nxt = '0;
        if (stall_ev) begin
            if (stall_cnt == CNT_MAX)
                cnt_nxt = stall_cnt;
            else
                cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out    <= 1'b0;
            pc_plus4_out <= '0;
            instr_out    <= NOP_INSTR;
            side_out     <= '0;
        end else if (flush) begin
            valid_out    <= 1'b0;
            pc_plus4_out <= KEEP_PC_ON_FLUSH ? pc_plus4_in : '0;
            instr_out    <= NOP_INSTR;
            side_out     <= '0;
        end else if (en) begin
            valid_out    <= valid_in;
            pc_plus4_out <= pc_plus4_in;
            instr_out    <= instr_in;
            side_out     <= side_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt     <= '0;
            stall_total   <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt     <= cnt_nxt;
            stall_timeout <= (cnt_nxt >= LIMIT);
            if (stall_ev)
                stall_total <= stall_total + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a small-counter,
// clear-PC-on-flush instance sharing the same stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, valid_in;
    logic [31:0] pc_in, instr_in;
    logic [7:0]  side_in;

    logic        v1, v2;
    logic [31:0] pc1, pc2, ins1, ins2;
    logic [7:0]  sd1, sd2;
    logic [7:0]  cnt1, tot1;
    logic [3:0]  cnt2, tot2;
    logic        to1, to2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .valid_in(valid_in), .pc_plus4_in(pc_in),
        .instr_in(instr_in), .side_in(side_in),
        .valid_out(v1), .pc_plus4_out(pc1), .instr_out(ins1),
        .side_out(sd1), .stall_cnt(cnt1), .stall_total(tot1),
        .stall_timeout(to1)
    );

    pipe_stage_reg #(
        .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(4), .STALL_LIMIT(10)
    ) dut2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .valid_in(valid_in), .pc_plus4_in(pc_in),
        .instr_in(instr_in), .side_in(side_in),
        .valid_out(v2), .pc_plus4_out(pc2), .instr_out(ins2),
        .side_out(sd2), .stall_cnt(cnt2), .stall_total(tot2),
        .stall_timeout(to2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0;
        pc_in = '0; instr_in = '0; side_in = '0;
        tick();
        tick();
        chk("rst_valid", 64'(v1), 64'd0);
        chk("rst_pc", 64'(pc1), 64'd0);
        chk("rst_instr", 64'(ins1), 64'd0);
        chk("rst_side", 64'(sd1), 64'd0);
        chk("rst_cnt", 64'(cnt1), 64'd0);
        chk("rst_total", 64'(tot1), 64'd0);
        chk("rst_timeout", 64'(to1), 64'd0);

        reset = 1'b0; en = 1'b1; valid_in = 1'b1;
        pc_in = 32'h0000_3004; instr_in = 32'h2401_0005; side_in = 8'h00;
        tick();
        chk("load_pc", 64'(pc1), 64'h3004);
        chk("load_instr", 64'(ins1), 64'h2401_0005);
        chk("load_valid", 64'(v1), 64'd1);

        // stall with changing (and once unknown) inputs
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pc_in = 32'(i);
            instr_in = (i == 3) ? 'x : 32'(i * 7);
            side_in = (i == 3) ? 'x : 8'(i);
            tick();
            chk("hold_pc", 64'(pc1), 64'h3004);
            chk("hold_instr", 64'(ins1), 64'h2401_0005);
            chk("hold_side", 64'(sd1), 64'd0);
            chk("hold_valid", 64'(v1), 64'd1);
            chk("hold_cnt", 64'(cnt1), 64'(i));
        end
        chk("hold_total", 64'(tot1), 64'd5);
        chk("hold_timeout", 64'(to1), 64'd0);

        en = 1'b1; pc_in = 32'h0000_3008; instr_in = 32'h8c22_0004;
        side_in = 8'h5a;
        tick();
        chk("resume_cnt", 64'(cnt1), 64'd0);
        chk("resume_pc", 64'(pc1), 64'h3008);
        chk("resume_instr", 64'(ins1), 64'h8c22_0004);
        chk("resume_side", 64'(sd1), 64'h5a);
        chk("resume_total", 64'(tot1), 64'd5);

        en = 1'b0; flush = 1'b1; pc_in = 32'h0000_3010;
        tick();
        chk("flush_valid", 64'(v1), 64'd0);
        chk("flush_instr", 64'(ins1), 64'd0);
        chk("flush_side", 64'(sd1), 64'd0);
        chk("flush_pc_keep", 64'(pc1), 64'h3010);
        chk("flush_pc_clear", 64'(pc2), 64'd0);
        chk("flush_cnt", 64'(cnt1), 64'd0);

        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bubble_cnt", 64'(cnt1), 64'd0);
            chk("bubble_total", 64'(tot1), 64'd5);
            chk("bubble_valid", 64'(v1), 64'd0);
        end

        // timeout / saturation, small counter instance
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; valid_in = 1'b1;
        pc_in = 32'h0000_4000; instr_in = 32'h0000_0020; side_in = 8'h01;
        tick();
        en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_cnt2", 64'(cnt2), 64'((k > 15) ? 15 : k));
            chk("sat_to2", 64'(to2), 64'((k >= 10) ? 1 : 0));
            chk("sat_cnt1", 64'(cnt1), 64'(k));
            chk("sat_to1", 64'(to1), 64'((k >= 16) ? 1 : 0));
        end
        chk("wrap_total2", 64'(tot2), 64'd4);
        chk("total1_20", 64'(tot1), 64'd20);
        en = 1'b1;
        tick();
        chk("drop_to2", 64'(to2), 64'd0);
        chk("drop_cnt2", 64'(cnt2), 64'd0);
        chk("drop_to1", 64'(to1), 64'd0);

        // reset in the middle of a stall
        en = 1'b0;
        for (int k = 0; k < 7; k++)
            tick();
        chk("mid_cnt7", 64'(cnt1), 64'd7);
        reset = 1'b1;
        tick();
        chk("midrst_cnt", 64'(cnt1), 64'd0);
        chk("midrst_total", 64'(tot1), 64'd0);
        chk("midrst_valid", 64'(v1), 64'd0);
        chk("midrst_to", 64'(to1), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_cnt", 64'(cnt1), 64'd0);
        chk("post_rst_total", 64'(tot1), 64'd0);
        chk("post_rst_pc", 64'(pc1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
